// File: rtl/mem_wait_pkg.sv
// Shared types and default sizing for the memory-wait pipeline stage.
package mem_wait_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int DEF_INSTR_W  = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MAX_WAIT = 7;
    localparam int DEF_TIMEOUT  = 16;

endpackage

// File: rtl/mem_wait_ctr.sv
// Wait-state down-counter plus the missing-ready timeout counter.
module mem_wait_ctr
    import mem_wait_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int CNT_W    = $clog2(MAX_WAIT + 1),
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             run,
    input  logic             mem_rdy,
    output logic             cnt_zero,
    output logic             tmo_hit
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WAIT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt;
    logic [TMO_W-1:0] tmo;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            tmo <= '0;
        end else if (load) begin
            cnt <= (load_val > MAX_CNT) ? MAX_CNT : load_val;
            tmo <= '0;
        end else if (run) begin
            if (cnt != '0)
                cnt <= cnt - 1'b1;
            else if (!mem_rdy && tmo != TMO_MAX)
                tmo <= tmo + 1'b1;
        end
    end

    assign cnt_zero = (cnt == '0);
    // Fires in the TIMEOUT-th consecutive cycle without ready once wait states are done.
    assign tmo_hit  = run && cnt_zero && !mem_rdy && (tmo == TMO_LAST);

endmodule

// File: rtl/mem_wait_stage.sv
// Execute->writeback stage: registers instr + branch tag, waits out memory accesses,
// squashes wrong-path work and flags memory timeouts.
module mem_wait_stage
    import mem_wait_pkg::*;
#(
    parameter int INSTR_W  = DEF_INSTR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int CNT_W    = $clog2(MAX_WAIT + 1),
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               valid_in,
    input  logic               is_mem_in,
    input  logic               branch_in,
    input  logic               branch_ref,
    input  logic               sel_stall,
    input  logic [CNT_W-1:0]   wait_cycles,
    output logic               mem_req,
    input  logic               mem_rdy,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               stall_req,
    output logic [INSTR_W-1:0] instr_output,
    output logic               valid_out,
    output logic [DATA_W-1:0]  rdata_out,
    output logic               branch_value,
    output logic               timeout_err
);

    state_e state;
    logic   cnt_zero;
    logic   tmo_hit;
    logic   accept;
    logic   squash;

    // Drops in the same cycle a released HOLD can take the next instruction.
    assign stall_req = (state == WAIT) || (valid_out && sel_stall);
    assign accept    = valid_in && !stall_req && (branch_in == branch_ref);
    assign squash    = (branch_value != branch_ref);

    mem_wait_ctr #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT)
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && is_mem_in),
        .load_val (wait_cycles),
        .run      (state == WAIT),
        .mem_rdy  (mem_rdy),
        .cnt_zero (cnt_zero),
        .tmo_hit  (tmo_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            instr_output <= '0;
            valid_out    <= 1'b0;
            rdata_out    <= '0;
            branch_value <= 1'b0;
            mem_req      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            if (state == WAIT) begin
                // Squash outranks both data return and timeout.
                if (squash) begin
                    state     <= IDLE;
                    mem_req   <= 1'b0;
                    valid_out <= 1'b0;
                end else if (cnt_zero && mem_rdy) begin
                    rdata_out <= mem_rdata;
                    mem_req   <= 1'b0;
                    valid_out <= 1'b1;
                    state     <= HOLD;
                end else if (tmo_hit) begin
                    timeout_err <= 1'b1;
                    rdata_out   <= '0;
                    mem_req     <= 1'b0;
                    valid_out   <= 1'b1;
                    state       <= HOLD;
                end
            end else if (state == HOLD && sel_stall) begin
                if (squash) begin
                    state     <= IDLE;
                    valid_out <= 1'b0;
                end
            end else if (accept) begin
                // IDLE, or HOLD whose output is consumed this cycle.
                instr_output <= instr_in;
                branch_value <= branch_in;
                if (is_mem_in) begin
                    mem_req   <= 1'b1;
                    valid_out <= 1'b0;
                    state     <= WAIT;
                end else begin
                    valid_out <= 1'b1;
                    state     <= HOLD;
                end
            end else begin
                valid_out <= 1'b0;
                state     <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mem_wait_stage.sv
// Bench for mem_wait_stage: vector table with a scoreboard on consumed outputs,
// plus hand sequences for stall, reset-in-wait, timeout and squash.
module tb_mem_wait_stage;

    localparam int INSTR_W  = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 7;
    localparam int CNT_W    = 4;   // wide enough to present values above MAX_WAIT
    localparam int TIMEOUT  = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [INSTR_W-1:0] instr_in;
    logic               valid_in, is_mem_in, branch_in, branch_ref, sel_stall;
    logic [CNT_W-1:0]   wait_cycles;
    logic               mem_req, mem_rdy, stall_req, valid_out, branch_value, timeout_err;
    logic [DATA_W-1:0]  mem_rdata, rdata_out;
    logic [INSTR_W-1:0] instr_output;

    always #5 clk = ~clk;

    mem_wait_stage #(
        .INSTR_W (INSTR_W), .DATA_W (DATA_W), .MAX_WAIT (MAX_WAIT),
        .CNT_W (CNT_W), .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk), .rst (rst), .instr_in (instr_in), .valid_in (valid_in),
        .is_mem_in (is_mem_in), .branch_in (branch_in), .branch_ref (branch_ref),
        .sel_stall (sel_stall), .wait_cycles (wait_cycles), .mem_req (mem_req),
        .mem_rdy (mem_rdy), .mem_rdata (mem_rdata), .stall_req (stall_req),
        .instr_output (instr_output), .valid_out (valid_out), .rdata_out (rdata_out),
        .branch_value (branch_value), .timeout_err (timeout_err)
    );

    typedef struct {
        logic [31:0]      instr;
        logic             is_mem;
        logic [CNT_W-1:0] wt;
        logic [31:0]      rdata;
        logic             tag_ok;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rdata;
        logic        tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        tbl[7];
    vec_t        sat_v;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // An output is consumed at an edge where it is valid and not stalled downstream.
    always @(negedge clk) begin
        if (!rst && valid_out && !sel_stall) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got instr %h, expected no output", instr_output);
            end else begin
                mon_e = sb.pop_front();
                check("sb_instr", instr_output, mon_e.instr);
                check("sb_rdata", rdata_out, mon_e.rdata);
                check("sb_tag", 32'(branch_value), 32'(mon_e.tag));
            end
        end
    end

    task automatic run_vec(input vec_t v, input string nm);
        int   c;
        int   reqc;
        int   sat;
        logic tg;
        sat = (v.wt > MAX_WAIT) ? MAX_WAIT : int'(v.wt);
        tg  = v.tag_ok ? branch_ref : ~branch_ref;
        instr_in    = v.instr;
        is_mem_in   = v.is_mem;
        branch_in   = tg;
        wait_cycles = v.wt;
        mem_rdy     = 1'b1;
        mem_rdata   = v.rdata;
        sel_stall   = 1'b0;
        valid_in    = 1'b1;
        #1;
        check({nm, "_stall_pre"}, 32'(stall_req), 32'd0);
        if (v.tag_ok) begin
            if (v.is_mem) last_rdata = v.rdata;
            sb.push_back('{v.instr, last_rdata, tg});
        end
        tick();
        valid_in = 1'b0;
        if (!v.tag_ok) begin
            check({nm, "_drop_valid"}, 32'(valid_out), 32'd0);
            check({nm, "_drop_req"}, 32'(mem_req), 32'd0);
        end else begin
            c    = 0;
            reqc = 0;
            if (v.is_mem) check({nm, "_stall_wait"}, 32'(stall_req), 32'd1);
            while (!valid_out && c < 40) begin
                if (mem_req) reqc++;
                tick();
                c++;
            end
            check({nm, "_latency"}, c, v.is_mem ? sat + 1 : 0);
            check({nm, "_req_cycles"}, reqc, v.is_mem ? sat + 1 : 0);
            check({nm, "_req_done"}, 32'(mem_req), 32'd0);
            check({nm, "_no_tmo"}, 32'(timeout_err), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        int tmo_early;

        tbl[0] = '{32'hE0811002, 1'b0, 4'd0, 32'h0000_0000, 1'b1};
        tbl[1] = '{32'hE5912000, 1'b1, 4'd3, 32'hDEADBEEF, 1'b1};
        tbl[2] = '{32'hE0822003, 1'b0, 4'd0, 32'h0000_0000, 1'b0};
        tbl[3] = '{32'hE5934004, 1'b1, 4'd0, 32'h12345678, 1'b1};
        tbl[4] = '{32'hE1A00000, 1'b0, 4'd0, 32'h0000_0000, 1'b1};
        tbl[5] = '{32'hE5956008, 1'b1, 4'd5, 32'hCAFEF00D, 1'b1};
        tbl[6] = '{32'hE5867000, 1'b1, 4'd7, 32'h0BADC0DE, 1'b1};
        sat_v  = '{32'hE5971000, 1'b1, 4'd9, 32'h5A5A1234, 1'b1};

        rst = 1'b1; instr_in = '0; valid_in = 1'b0; is_mem_in = 1'b0; branch_in = 1'b0;
        branch_ref = 1'b0; sel_stall = 1'b0; wait_cycles = '0; mem_rdy = 1'b0;
        mem_rdata = '0; last_rdata = '0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_instr", instr_output, 32'd0);
        check("rst_rdata", rdata_out, 32'd0);
        check("rst_tmo", 32'(timeout_err), 32'd0);

        for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Downstream stall with a new instruction waiting upstream.
        instr_in = 32'hE2833001; is_mem_in = 1'b0; branch_in = branch_ref; valid_in = 1'b1;
        sb.push_back('{32'hE2833001, last_rdata, branch_ref});
        tick();
        sel_stall = 1'b1;
        instr_in  = 32'hE2844002;
        sb.push_back('{32'hE2844002, last_rdata, branch_ref});
        #1;
        for (int i = 0; i < 5; i++) begin
            check("hold_instr", instr_output, 32'hE2833001);
            check("hold_valid", 32'(valid_out), 32'd1);
            check("hold_stall", 32'(stall_req), 32'd1);
            tick();
        end
        sel_stall = 1'b0;
        #1;
        check("release_stall", 32'(stall_req), 32'd0);
        tick();
        valid_in = 1'b0;
        check("release_instr", instr_output, 32'hE2844002);
        check("release_valid", 32'(valid_out), 32'd1);
        tick();

        // Reset during WAIT aborts the access.
        instr_in = 32'hE5988000; is_mem_in = 1'b1; wait_cycles = 4'd5; mem_rdy = 1'b1;
        mem_rdata = 32'h11112222; branch_in = branch_ref; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_rdata = '0;
        check("wrst_valid", 32'(valid_out), 32'd0);
        check("wrst_req", 32'(mem_req), 32'd0);
        check("wrst_stall", 32'(stall_req), 32'd0);
        check("wrst_instr", instr_output, 32'd0);
        check("wrst_rdata", rdata_out, 32'd0);
        check("wrst_tag", 32'(branch_value), 32'd0);
        run_vec(sat_v, "sat");

        // Timeout: early ready ignored, then ready never arrives.
        instr_in = 32'hE5910000; is_mem_in = 1'b1; wait_cycles = 4'd2; mem_rdy = 1'b0;
        mem_rdata = 32'h77778888; branch_in = branch_ref; valid_in = 1'b1;
        last_rdata = '0;
        sb.push_back('{32'hE5910000, 32'h0, branch_ref});
        tick();
        valid_in  = 1'b0;
        c         = 0;
        tmo_early = 0;
        while (!valid_out && c < 60) begin
            mem_rdy = (c == 1);
            if (timeout_err) tmo_early++;
            tick();
            c++;
        end
        mem_rdy = 1'b0;
        check("tmo_latency", c, 32'd18);
        check("tmo_early", tmo_early, 32'd0);
        check("tmo_pulse", 32'(timeout_err), 32'd1);
        check("tmo_rdata", rdata_out, 32'd0);
        tick();
        check("tmo_pulse_end", 32'(timeout_err), 32'd0);

        // Squash mid-WAIT with ready arriving the same cycle.
        instr_in = 32'hE5920000; is_mem_in = 1'b1; wait_cycles = 4'd2; mem_rdy = 1'b0;
        mem_rdata = 32'h99990000; branch_in = branch_ref; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        tick();
        branch_ref = ~branch_ref;
        mem_rdy    = 1'b1;
        #1;
        check("sq_req_before", 32'(mem_req), 32'd1);
        tick();
        check("sq_valid", 32'(valid_out), 32'd0);
        check("sq_req", 32'(mem_req), 32'd0);
        check("sq_tmo", 32'(timeout_err), 32'd0);
        check("sq_stall", 32'(stall_req), 32'd0);
        instr_in = 32'hE0833333; is_mem_in = 1'b0; branch_in = ~branch_ref; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        check("sq_drop_valid", 32'(valid_out), 32'd0);
        tick();
        check("sq_drop_valid2", 32'(valid_out), 32'd0);

        tick();
        check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_wait_stage.md
Name: mem_wait_stage

Overview:
- Parametrised successor to the memory-wait pipeline stage of the pipelined ARM core.
- Sits between execute and writeback.
- Registers the instruction together with its branch tag, and holds memory instructions for a programmable number of wait states plus a ready handshake.
- Squashes wrong-path instructions on branch-tag mismatch, back-pressures upstream, and reports memory timeouts.

Parameters:
INSTR_W, 32, instruction word width
DATA_W, 32, memory read-data width
MAX_WAIT, 7, largest programmable wait-state count
CNT_W, $clog2(MAX_WAIT+1), wait counter width
TIMEOUT, 16, cycles after wait states expire before a missing mem_rdy is declared a timeout (must be ≥1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
instr_in  in  INSTR_W  instruction from execute stage
valid_in  in  1  instr_in is valid this cycle
is_mem_in  in  1  instr_in is a load/store
branch_in  in  1  branch tag carried by instr_in
branch_ref  in  1  current architectural branch tag
sel_stall  in  1  downstream stall: hold outputs
wait_cycles  in  CNT_W  wait states per access; sampled at accept; values above MAX_WAIT saturate
mem_req  out  1  memory access in progress
mem_rdy  in  1  memory data valid
mem_rdata  in  DATA_W  memory read data
stall_req  out  1  upstream must hold instr_in/valid_in
instr_output  out  INSTR_W  registered instruction
valid_out  out  1  instr_output valid
rdata_out  out  DATA_W  captured read data
branch_value  out  1  registered branch tag of instr_output
timeout_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: state=IDLE; all outputs 0; counters 0. Reset during WAIT aborts the access, and mem_req drops on the next edge.
- Accept condition: valid_in && !stall_req && (branch_in==branch_ref). A valid_in with a tag mismatch is dropped as a bubble.
- FSM states:
  - IDLE/PASS: on accept with !is_mem_in, register instr, tag, valid_out=1 next cycle (latency 1), rdata_out unchanged. On accept with is_mem_in, load cnt=min(wait_cycles,MAX_WAIT), mem_req=1, go WAIT, valid_out=0.
  - WAIT: cnt decrements each cycle while >0. mem_rdy is honoured only when cnt==0; an early mem_rdy is ignored. When cnt==0 && mem_rdy: capture mem_rdata, mem_req=0, valid_out=1, go HOLD. Total latency from accept to valid_out is wait_cycles+1 when mem_rdy is already high.
  - Timeout: while cnt==0 && !mem_rdy, tmo counter increments. At tmo==TIMEOUT: timeout_err pulses 1 cycle, rdata_out=0, valid_out=1, mem_req=0, go HOLD.
  - HOLD: outputs stable while sel_stall=1. When sel_stall=0, the stage behaves as IDLE in the same cycle: it may accept the next instruction, giving back-to-back throughput.
- Squash: if the held tag != branch_ref during WAIT or HOLD:
  - valid_out=0 and mem_req=0 next cycle, state=IDLE.
  - No timeout_err.
  - Squash has priority over mem_rdy and timeout in the same cycle.
- stall_req = (state==WAIT) || (valid_out && sel_stall). It is combinational and deasserts in the cycle the FSM will accept.
- With sel_stall=1 in IDLE and valid_out=0 (bubble), the stage still accepts.
- wait_cycles=0 means a single-cycle access if mem_rdy is high.

Decomposition:
- Package mem_wait_pkg: state enum {IDLE, WAIT, HOLD}; default parameter constants.
- Sub-module mem_wait_ctr: a loadable down-counter plus the timeout counter, with cnt_zero and tmo_hit outputs.
- The stage itself holds the FSM and the datapath registers.

Test Plan:
- ALU instr 32'hE0811002, valid, tags equal, is_mem=0 → next cycle instr_output=32'hE0811002, valid_out=1, branch_value=tag, stall_req=0.
- LDR, wait_cycles=3, mem_rdy=1 with mem_rdata=32'hDEADBEEF → mem_req high 4 cycles, stall_req high during WAIT, valid_out=1 on cycle 4 with rdata_out=32'hDEADBEEF.
- LDR, wait_cycles=2, mem_rdy pulsed at cycle 1 then held 0 → the cycle-1 pulse is ignored; at 2+16 cycles timeout_err is a single pulse, rdata_out=0, valid_out=1.
- LDR accepted, branch_ref toggled mid-WAIT with mem_rdy=1 the same cycle → valid_out stays 0, mem_req=0 next cycle, timeout_err=0; instr_in with a mismatched tag is also dropped.
- Output valid, sel_stall=1 for 5 cycles with new valid_in → outputs frozen and stall_req=1; on release the new instr is registered the next cycle with no loss or duplication.
- rst asserted in WAIT cycle 2 → next edge all outputs 0, state IDLE; wait_cycles=9 (>MAX_WAIT) afterwards → saturates to 7 wait states.
